// File: rtl/m_instr_sequencer_pkg.sv
// Shared constants, opcode/state encodings and decode helpers for the MPU instruction sequencer.
package m_instr_sequencer_pkg;

   localparam int SEQ_WORD       = 8;
   localparam int SEQ_DWORD      = 16;
   localparam int SEQ_MUX        = 2;
   localparam int SEQ_FIFO_DEPTH = 4;

   localparam int OP_MSB    = 15;
   localparam int OP_LSB    = 13;
   localparam int DEMUX_BIT = 12;
   localparam int MUX_MSB   = 11;
   localparam int MUX_LSB   = 10;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_LDI  = 3'd1,
      OP_ADD  = 3'd2,
      OP_SUB  = 3'd3,
      OP_AND  = 3'd4,
      OP_OR   = 3'd5,
      OP_CMP  = 3'd6,
      OP_WAIT = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_ISSUE  = 2'd2,
      S_WAIT   = 2'd3
   } state_e;

   function automatic logic is_acc_op(input op_e op);
      return (op == OP_LDI) || (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_AND) || (op == OP_OR);
   endfunction

endpackage

// File: rtl/m_instr_sequencer_if.sv
// Host instruction channel and datapath control-word channel of the sequencer.
interface m_instr_sequencer_if
   import m_instr_sequencer_pkg::*;
#(
   parameter int WORD  = SEQ_WORD,
   parameter int DWORD = SEQ_DWORD,
   parameter int MUX   = SEQ_MUX
);
   logic             in_valid;
   logic [DWORD-1:0] in_instr;
   logic             in_ready;
   logic             ctrl_valid;
   logic             ctrl_ready;
   logic [2:0]       ctrl_alu_op;
   logic [WORD-1:0]  ctrl_operand;
   logic [MUX-1:0]   ctrl_mux_sel;
   logic             ctrl_demux_sel;
   logic             ctrl_acc_we;
   logic             ctrl_cmp_en;
   logic [WORD-1:0]  ctrl_cmp_mask;

   // master: host + datapath side; slave: the sequencer
   modport master (
      output in_valid, in_instr, ctrl_ready,
      input  in_ready, ctrl_valid, ctrl_alu_op, ctrl_operand, ctrl_mux_sel,
             ctrl_demux_sel, ctrl_acc_we, ctrl_cmp_en, ctrl_cmp_mask
   );

   modport slave (
      input  in_valid, in_instr, ctrl_ready,
      output in_ready, ctrl_valid, ctrl_alu_op, ctrl_operand, ctrl_mux_sel,
             ctrl_demux_sel, ctrl_acc_we, ctrl_cmp_en, ctrl_cmp_mask
   );
endinterface

// File: rtl/m_sync_fifo.sv
// Synchronous FIFO, registered write, no fall-through; extra pointer bit separates full from empty.
module m_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/m_instr_sequencer.sv
// Instruction front-end: FIFO, mask-qualified decode, control-word issue and counted WAIT.
// Optional macro M_SEQ_PERF_EN adds the retired_cnt output.
//
// state  | meaning
// IDLE   | waiting for a queued instruction; pops it when present
// DECODE | samples host masks, classifies the popped instruction
// ISSUE  | control word valid, held until the datapath takes it
// WAIT   | counting down a WAIT instruction's immediate
module m_instr_sequencer
   import m_instr_sequencer_pkg::*;
#(
   parameter int WORD       = SEQ_WORD,
   parameter int DWORD      = SEQ_DWORD,
   parameter int MUX        = SEQ_MUX,
   parameter int FIFO_DEPTH = SEQ_FIFO_DEPTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [WORD-1:0] h_IMASK,
   input  logic [WORD-1:0] h_PMASK,
   input  logic [WORD-1:0] h_CMASK,
   m_instr_sequencer_if.slave bus,
   output logic            busy,
   output logic [WORD-1:0] masked_cnt
`ifdef M_SEQ_PERF_EN
   ,
   output logic [DWORD-1:0] retired_cnt
`endif
);
   state_e           state_q, state_d;
   logic [DWORD-1:0] instr_q, instr_d;
   logic [WORD-1:0]  cnt_q, cnt_d;
   logic [WORD-1:0]  masked_q, masked_d;
   op_e              alu_op_q, alu_op_d;
   logic [WORD-1:0]  operand_q, operand_d;
   logic [MUX-1:0]   mux_q, mux_d;
   logic             demux_q, demux_d;
   logic             acc_we_q, acc_we_d;
   logic             cmp_en_q, cmp_en_d;
   logic [WORD-1:0]  cmask_q, cmask_d;
   logic             rdy_en_q;

   logic             push, pop, fifo_full, fifo_empty;
   logic [DWORD-1:0] fifo_dout;
   op_e              op;
   logic [WORD-1:0]  imm;
   logic             unused_rsvd;

   assign op          = op_e'(instr_q[OP_MSB:OP_LSB]);
   assign imm         = instr_q[WORD-1:0];
   assign unused_rsvd = ^instr_q[MUX_LSB-1:WORD];

   // rdy_en_q keeps in_ready low while reset is held
   assign bus.in_ready = rdy_en_q && !fifo_full;
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = (state_q == S_IDLE) && !fifo_empty;

   m_sync_fifo #(.WIDTH(DWORD), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (bus.in_instr),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      cnt_d     = cnt_q;
      masked_d  = masked_q;
      alu_op_d  = alu_op_q;
      operand_d = operand_q;
      mux_d     = mux_q;
      demux_d   = demux_q;
      acc_we_d  = acc_we_q;
      cmp_en_d  = cmp_en_q;
      cmask_d   = cmask_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               instr_d = fifo_dout;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!h_IMASK[op]) begin
               if (masked_q != '1) masked_d = masked_q + WORD'(1);
               state_d = S_IDLE;
            end else if (op == OP_NOP) begin
               state_d = S_IDLE;
            end else if (op == OP_WAIT) begin
               cnt_d   = imm;
               state_d = (imm == '0) ? S_IDLE : S_WAIT;
            end else begin
               alu_op_d  = op;
               operand_d = imm & h_PMASK;
               mux_d     = instr_q[MUX_MSB:MUX_LSB];
               demux_d   = instr_q[DEMUX_BIT];
               acc_we_d  = is_acc_op(op);
               cmp_en_d  = (op == OP_CMP);
               cmask_d   = (op == OP_CMP) ? h_CMASK : '0;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.ctrl_ready) state_d = S_IDLE;
         end
         S_WAIT: begin
            cnt_d = cnt_q - WORD'(1);
            if (cnt_q == WORD'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         instr_q   <= '0;
         cnt_q     <= '0;
         masked_q  <= '0;
         alu_op_q  <= OP_NOP;
         operand_q <= '0;
         mux_q     <= '0;
         demux_q   <= 1'b0;
         acc_we_q  <= 1'b0;
         cmp_en_q  <= 1'b0;
         cmask_q   <= '0;
         rdy_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         cnt_q     <= cnt_d;
         masked_q  <= masked_d;
         alu_op_q  <= alu_op_d;
         operand_q <= operand_d;
         mux_q     <= mux_d;
         demux_q   <= demux_d;
         acc_we_q  <= acc_we_d;
         cmp_en_q  <= cmp_en_d;
         cmask_q   <= cmask_d;
         rdy_en_q  <= 1'b1;
      end
   end

   assign bus.ctrl_valid     = (state_q == S_ISSUE);
   assign bus.ctrl_alu_op    = alu_op_q;
   assign bus.ctrl_operand   = operand_q;
   assign bus.ctrl_mux_sel   = mux_q;
   assign bus.ctrl_demux_sel = demux_q;
   assign bus.ctrl_acc_we    = acc_we_q;
   assign bus.ctrl_cmp_en    = cmp_en_q;
   assign bus.ctrl_cmp_mask  = cmask_q;
   assign busy               = (state_q != S_IDLE) || !fifo_empty;
   assign masked_cnt         = masked_q;

`ifdef M_SEQ_PERF_EN
   logic [DWORD-1:0] retired_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retired_q <= '0;
      end else if ((bus.ctrl_valid && bus.ctrl_ready) ||
                   (state_q == S_WAIT && cnt_q == WORD'(1))) begin
         retired_q <= retired_q + DWORD'(1);
      end
   end

   assign retired_cnt = retired_q;
`endif
endmodule

// File: tb/tb_m_instr_sequencer.sv
// Directed bench for m_instr_sequencer: decode table plus multi-cycle corner sequences.
module tb_m_instr_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] h_IMASK, h_PMASK, h_CMASK;
   logic       busy;
   logic [7:0] masked_cnt;
`ifdef M_SEQ_PERF_EN
   logic [15:0] retired_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int exp_masked = 0;

   m_instr_sequencer_if bus_if ();

   m_instr_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .h_IMASK    (h_IMASK),
      .h_PMASK    (h_PMASK),
      .h_CMASK    (h_CMASK),
      .bus        (bus_if),
      .busy       (busy),
      .masked_cnt (masked_cnt)
`ifdef M_SEQ_PERF_EN
      ,
      .retired_cnt(retired_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0] op;
      logic [7:0] imm;
      logic [7:0] pmask;
      logic [7:0] imask;
      logic [7:0] cmask;
      logic [1:0] mux;
      logic       dmx;
      logic       issue;
      logic [7:0] exp_operand;
      logic       exp_acc;
      logic       exp_cmp;
      logic [7:0] exp_cmask;
      int         masked_inc;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   function automatic logic [15:0] mk(input logic [2:0] op, input logic dmx,
                                      input logic [1:0] mux, input logic [7:0] imm);
      return {op, dmx, mux, 2'b11, imm};
   endfunction

   task automatic push_instr(input logic [15:0] ins);
      int n;
      n = 0;
      bus_if.in_instr = ins;
      bus_if.in_valid = 1'b1;
      while (!bus_if.in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("push_timeout", 32'd0, 32'd1);
      tick();
      bus_if.in_valid = 1'b0;
   endtask

   initial begin
      int idx;
      int n;
      int d0;
      int d3;
      logic busy_ok;
      logic seen;

      //        op  imm    pmask  imask  cmask  mux dmx iss operand acc cmp cmask inc
      vecs[0] = '{3'd1, 8'hA5, 8'h0F, 8'hFF, 8'h00, 2'd2, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 0};
      vecs[1] = '{3'd2, 8'h3C, 8'hFF, 8'hFF, 8'h11, 2'd1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 0};
      vecs[2] = '{3'd3, 8'hF0, 8'h3C, 8'hFF, 8'h00, 2'd3, 1'b1, 1'b1, 8'h30, 1'b1, 1'b0, 8'h00, 0};
      vecs[3] = '{3'd4, 8'h55, 8'hFF, 8'hEF, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1};
      vecs[4] = '{3'd5, 8'h81, 8'hF1, 8'hFF, 8'h00, 2'd0, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 8'h00, 0};
      vecs[5] = '{3'd6, 8'h7E, 8'h0F, 8'hFF, 8'hC3, 2'd2, 1'b0, 1'b1, 8'h0E, 1'b0, 1'b1, 8'hC3, 0};
      vecs[6] = '{3'd0, 8'h12, 8'hFF, 8'hFF, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0};
      vecs[7] = '{3'd6, 8'h44, 8'hFF, 8'hBF, 8'hFF, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1};
      vecs[8] = '{3'd7, 8'h00, 8'hFF, 8'hFF, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0};

      rst_n = 1'b0;
      h_IMASK = 8'hFF;
      h_PMASK = 8'hFF;
      h_CMASK = 8'h00;
      bus_if.in_valid = 1'b0;
      bus_if.in_instr = '0;
      bus_if.ctrl_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready", bus_if.in_ready, 0);
      check("rst_ctrl_valid", bus_if.ctrl_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_masked_cnt", masked_cnt, 0);
      check("rst_operand", bus_if.ctrl_operand, 0);
      rst_n = 1'b1;
      tick();
      check("rel_in_ready", bus_if.in_ready, 1);

      // decode table, ctrl_ready held high
      bus_if.ctrl_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         h_IMASK = vecs[i].imask;
         h_PMASK = vecs[i].pmask;
         h_CMASK = vecs[i].cmask;
         push_instr(mk(vecs[i].op, vecs[i].dmx, vecs[i].mux, vecs[i].imm));
         tick();
         tick();
         check($sformatf("v%0d_valid", i), bus_if.ctrl_valid, vecs[i].issue);
         if (vecs[i].issue) begin
            check($sformatf("v%0d_op", i), bus_if.ctrl_alu_op, vecs[i].op);
            check($sformatf("v%0d_operand", i), bus_if.ctrl_operand, vecs[i].exp_operand);
            check($sformatf("v%0d_mux", i), bus_if.ctrl_mux_sel, vecs[i].mux);
            check($sformatf("v%0d_demux", i), bus_if.ctrl_demux_sel, vecs[i].dmx);
            check($sformatf("v%0d_acc_we", i), bus_if.ctrl_acc_we, vecs[i].exp_acc);
            check($sformatf("v%0d_cmp_en", i), bus_if.ctrl_cmp_en, vecs[i].exp_cmp);
            check($sformatf("v%0d_cmp_mask", i), bus_if.ctrl_cmp_mask, vecs[i].exp_cmask);
         end
         exp_masked += vecs[i].masked_inc;
         tick();
         check($sformatf("v%0d_drop", i), bus_if.ctrl_valid, 0);
         check($sformatf("v%0d_busy", i), busy, 0);
         check($sformatf("v%0d_masked", i), masked_cnt, exp_masked);
      end

      // ADD stalled for 4 cycles; mask change after decode must not leak in
      h_IMASK = 8'hFF;
      h_PMASK = 8'hFF;
      bus_if.ctrl_ready = 1'b0;
      push_instr(mk(3'd2, 1'b0, 2'd1, 8'h3C));
      tick();
      tick();
      h_PMASK = 8'h00;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("stall%0d_valid", k), bus_if.ctrl_valid, 1);
         check($sformatf("stall%0d_op", k), bus_if.ctrl_alu_op, 3'd2);
         check($sformatf("stall%0d_operand", k), bus_if.ctrl_operand, 8'h3C);
         check($sformatf("stall%0d_mux", k), bus_if.ctrl_mux_sel, 2'd1);
         check($sformatf("stall%0d_acc_we", k), bus_if.ctrl_acc_we, 1);
         if (k < 3) tick();
      end
      bus_if.ctrl_ready = 1'b1;
      tick();
      check("stall_drop", bus_if.ctrl_valid, 0);
      h_PMASK = 8'hFF;

      // five back-to-back pushes, datapath stalled: FIFO fills, order preserved
      bus_if.ctrl_ready = 1'b0;
      for (int k = 0; k < 5; k++) push_instr(mk(3'd1, 1'b0, 2'd0, 8'(8'h10 + k)));
      check("fill_in_ready", bus_if.in_ready, 0);
      bus_if.ctrl_ready = 1'b1;
      idx = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus_if.ctrl_valid) begin
            check($sformatf("order%0d_operand", idx), bus_if.ctrl_operand, 8'(8'h10 + idx));
            idx++;
         end
         tick();
      end
      check("order_count", idx, 5);
      check("order_busy", busy, 0);

      // SUB enabled, AND masked by IMASK bit4
      h_IMASK = 8'hEB;
      push_instr(mk(3'd3, 1'b0, 2'd0, 8'h21));
      push_instr(mk(3'd4, 1'b0, 2'd0, 8'h22));
      exp_masked++;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus_if.ctrl_valid) begin
            check("mask_issue_op", bus_if.ctrl_alu_op, 3'd3);
            idx++;
         end
         tick();
      end
      check("mask_issue_count", idx, 1);
      check("mask_masked_cnt", masked_cnt, exp_masked);

      // WAIT 0 vs WAIT 3 ahead of OR
      h_IMASK = 8'hFF;
      push_instr(mk(3'd7, 1'b0, 2'd0, 8'd0));
      push_instr(mk(3'd5, 1'b0, 2'd0, 8'h0F));
      n = 0;
      while (!bus_if.ctrl_valid && n < 30) begin
         tick();
         n++;
      end
      d0 = n;
      check("wait0_delay", d0, 3);
      tick();
      push_instr(mk(3'd7, 1'b0, 2'd0, 8'd3));
      push_instr(mk(3'd5, 1'b0, 2'd0, 8'h0F));
      n = 0;
      busy_ok = 1'b1;
      while (!bus_if.ctrl_valid && n < 30) begin
         if (!busy) busy_ok = 1'b0;
         tick();
         n++;
      end
      d3 = n;
      check("wait3_delay", d3, 6);
      check("wait3_busy_held", busy_ok, 1);
      check("wait3_or_op", bus_if.ctrl_alu_op, 3'd5);
      tick();

      // reset while ISSUE holds a word and two more are queued
      bus_if.ctrl_ready = 1'b0;
      for (int k = 0; k < 3; k++) push_instr(mk(3'd1, 1'b0, 2'd0, 8'(k + 1)));
      check("pre_rst_valid", bus_if.ctrl_valid, 1);
      rst_n = 1'b0;
      tick();
      check("mid_rst_valid", bus_if.ctrl_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", bus_if.in_ready, 0);
      check("mid_rst_operand", bus_if.ctrl_operand, 0);
      check("mid_rst_acc_we", bus_if.ctrl_acc_we, 0);
      check("mid_rst_masked", masked_cnt, 0);
      exp_masked = 0;
      rst_n = 1'b1;
      bus_if.ctrl_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (bus_if.ctrl_valid) seen = 1'b1;
      end
      check("post_rst_no_issue", seen, 0);
      check("post_rst_in_ready", bus_if.in_ready, 1);

      // masked_cnt saturation
      h_IMASK = 8'h00;
      for (int k = 0; k < 256; k++) push_instr(mk(3'd2, 1'b0, 2'd0, 8'h00));
      n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      check("sat_drained", busy, 0);
      check("sat_masked_cnt", masked_cnt, 8'hFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
